// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one line-wide memory port between icache misses,
// dcache reads/writebacks and next-line instruction prefetches. A one-line
// prefetch buffer serves icache misses without a memory trip on a hit.
module cache_mem_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned OFF_W  = 5,
    parameter int unsigned PF_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ic_addr,
    input  logic              ic_read,
    output logic [LINE_W-1:0] ic_rdata,
    output logic              ic_resp,
    input  logic [31:0]       dc_addr,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              dc_resp,
    input  logic              pf_valid,
    input  logic [31:0]       pf_addr,
    output logic [31:0]       mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam bit PF_ON = (PF_EN != 0);

    typedef enum logic [1:0] {S_IDLE, S_IC, S_DC, S_PF} state_t;
    typedef enum logic {RR_IC, RR_DC} rr_t;

    state_t            state;
    rr_t               rr_last;
    logic              buf_valid;
    logic [31:0]       buf_addr;
    logic [LINE_W-1:0] buf_data;
    logic              pf_pend;
    logic [31:0]       pf_pend_addr;

    logic [31:0]       ic_line;
    logic [31:0]       dc_line;
    logic [31:0]       pf_line;
    logic              ic_hit;
    logic              dc_req;
    logic              grant_dc;
    logic              pf_go;
    logic              unused_offsets;

    // Line addresses, grant decision and the combinational response paths.
    always_comb begin
        ic_line  = {ic_addr[31:OFF_W], {OFF_W{1'b0}}};
        dc_line  = {dc_addr[31:OFF_W], {OFF_W{1'b0}}};
        pf_line  = {pf_addr[31:OFF_W], {OFF_W{1'b0}}};
        ic_hit   = PF_ON && (state == S_IDLE) && ic_read && buf_valid && (ic_line == buf_addr);
        dc_req   = dc_read | dc_write;
        // dcache wins when icache is idle or when icache was granted last tie
        grant_dc = dc_req && (!ic_read || (rr_last == RR_IC));
        // a hint whose line already sits in the buffer is held back, not fetched twice
        pf_go    = PF_ON && pf_pend && !(buf_valid && (pf_pend_addr == buf_addr));
        ic_resp  = ic_hit || ((state == S_IC) && mem_resp);
        dc_resp  = (state == S_DC) && mem_resp;
        ic_rdata = ic_hit ? buf_data : (ic_resp ? mem_rdata : '0);
        dc_rdata = dc_resp ? mem_rdata : '0;
        unused_offsets = ^{ic_addr[OFF_W-1:0], dc_addr[OFF_W-1:0], pf_addr[OFF_W-1:0]};
    end

    // Arbitration FSM with registered memory-side outputs, prefetch buffer and hint register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            rr_last      <= RR_IC;
            mem_addr     <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_wdata    <= '0;
            buf_valid    <= 1'b0;
            buf_addr     <= '0;
            buf_data     <= '0;
            pf_pend      <= 1'b0;
            pf_pend_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ic_hit) begin
                        buf_valid <= 1'b0;
                    end else if (ic_read || dc_req) begin
                        // round-robin pointer only moves on a real tie
                        if (ic_read && dc_req) begin
                            rr_last <= grant_dc ? RR_DC : RR_IC;
                        end
                        if (grant_dc) begin
                            state     <= S_DC;
                            mem_addr  <= dc_line;
                            mem_read  <= dc_read;
                            mem_write <= dc_write;
                            if (dc_write) begin
                                mem_wdata <= dc_wdata;
                                if (dc_line == buf_addr) begin
                                    buf_valid <= 1'b0;
                                end
                            end
                        end else begin
                            state    <= S_IC;
                            mem_addr <= ic_line;
                            mem_read <= 1'b1;
                        end
                    end else if (pf_go) begin
                        state    <= S_PF;
                        mem_addr <= pf_pend_addr;
                        mem_read <= 1'b1;
                        pf_pend  <= 1'b0;
                    end
                end
                S_IC, S_DC: begin
                    if (mem_resp) begin
                        state     <= S_IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                S_PF: begin
                    if (mem_resp) begin
                        state     <= S_IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        buf_data  <= mem_rdata;
                        buf_addr  <= mem_addr;
                        buf_valid <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // a new hint overrides both an older hint and the clear on issue
            if (PF_ON && pf_valid) begin
                pf_pend      <= 1'b1;
                pf_pend_addr <= pf_line;
            end
        end
    end

    // Requester handshake rules.
    a_dc_excl:  assert property (@(posedge clk) disable iff (rst) !(dc_read && dc_write));
    a_ic_hold:  assert property (@(posedge clk) disable iff (rst) (ic_read && !ic_resp) |=> ic_read);
    a_dcr_hold: assert property (@(posedge clk) disable iff (rst) (dc_read && !dc_resp) |=> dc_read);
    a_dcw_hold: assert property (@(posedge clk) disable iff (rst) (dc_write && !dc_resp) |=> dc_write);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: requesters push expected lines,
// a negedge monitor pops and compares on every ic_resp/dc_resp.
module tb_cache_mem_arbiter;

    localparam int LINE_W = 256;
    localparam int OFF_W  = 5;

    logic              clk, rst;
    logic [31:0]       ic_addr, dc_addr, pf_addr, mem_addr;
    logic              ic_read, ic_resp, dc_read, dc_write, dc_resp, pf_valid;
    logic              mem_read, mem_write, mem_resp;
    logic [LINE_W-1:0] ic_rdata, dc_rdata, dc_wdata, mem_wdata, mem_rdata;

    cache_mem_arbiter #(.LINE_W(LINE_W), .OFF_W(OFF_W), .PF_EN(1)) dut (
        .clk(clk), .rst(rst),
        .ic_addr(ic_addr), .ic_read(ic_read), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
        .dc_addr(dc_addr), .dc_read(dc_read), .dc_write(dc_write), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_resp(dc_resp),
        .pf_valid(pf_valid), .pf_addr(pf_addr),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic              chk;
        logic [LINE_W-1:0] data;
    } exp_t;
    exp_t ic_q[$];
    exp_t dc_q[$];
    int   resp_log[$];
    int   last_ic_cyc = 0;

    logic [LINE_W-1:0] ref_mem [logic [31:0]];
    logic [LINE_W-1:0] mem_arr [logic [31:0]];

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return {a[31:OFF_W], {OFF_W{1'b0}}};
    endfunction

    function automatic logic [LINE_W-1:0] init_line(input logic [31:0] a);
        logic [LINE_W-1:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = a ^ (32'h0101_0101 * k) ^ 32'h5A5A_0000;
        return v;
    endfunction

    function automatic logic [LINE_W-1:0] ref_line(input logic [31:0] a);
        logic [31:0] la;
        la = line_of(a);
        return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Memory model: fixed or random latency, one-cycle mem_resp, stores writes.
    int          fixed_lat = 0;
    int          lat_cnt = 0;
    int          ops_started = 0;
    int          ops_done = 0;
    int          last_resp_cyc = 0;
    logic [31:0] last_addr = '0;
    logic        last_wr = 1'b0;

    initial begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                lat_cnt  = 0;
                mem_resp = 1'b0;
            end else if (mem_resp) begin
                mem_resp = 1'b0;
            end else if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    if (mem_write) mem_arr[mem_addr] = mem_wdata;
                    else mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_line(mem_addr);
                    mem_resp      = 1'b1;
                    ops_done++;
                    last_resp_cyc = cyc_cnt;
                end
            end else if (mem_read || mem_write) begin
                check("mem_addr_aligned", mem_addr[OFF_W-1:0], 0);
                check("mem_rw_exclusive", mem_read && mem_write, 0);
                ops_started++;
                last_addr = mem_addr;
                last_wr   = mem_write;
                lat_cnt   = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
            end
        end
    end

    // Monitor: pops the scoreboard on every response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ic_resp) begin
                    resp_log.push_back(1);
                    last_ic_cyc = cyc_cnt;
                    check("ic_resp_expected", ic_q.size() != 0, 1);
                    if (ic_q.size() != 0) begin
                        e = ic_q.pop_front();
                        check("ic_rdata", ic_rdata, e.data);
                    end
                end
                if (dc_resp) begin
                    resp_log.push_back(2);
                    check("dc_resp_expected", dc_q.size() != 0, 1);
                    if (dc_q.size() != 0) begin
                        e = dc_q.pop_front();
                        if (e.chk) check("dc_rdata", dc_rdata, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic ic_issue(input logic [31:0] a);
        ic_addr = a;
        ic_read = 1'b1;
        ic_q.push_back('{1'b1, ref_line(a)});
    endtask

    task automatic ic_finish(output int lat);
        int c = 0;
        @(negedge clk);
        while (!ic_resp && c < 300) begin c++; @(negedge clk); end
        check("ic_resp_within_bound", ic_resp, 1);
        lat = c;
        @(posedge clk); #2;
        ic_read = 1'b0;
    endtask

    task automatic ic_op(input logic [31:0] a, output int lat);
        tick();
        ic_issue(a);
        ic_finish(lat);
    endtask

    task automatic dc_issue(input logic wr, input logic [31:0] a, input logic [LINE_W-1:0] d);
        dc_addr  = a;
        dc_read  = !wr;
        dc_write = wr;
        dc_wdata = d;
        if (wr) begin
            ref_mem[line_of(a)] = d;
            dc_q.push_back('{1'b0, d});
        end else begin
            dc_q.push_back('{1'b1, ref_line(a)});
        end
    endtask

    task automatic dc_finish(output int lat);
        int c = 0;
        @(negedge clk);
        while (!dc_resp && c < 300) begin c++; @(negedge clk); end
        check("dc_resp_within_bound", dc_resp, 1);
        lat = c;
        @(posedge clk); #2;
        dc_read  = 1'b0;
        dc_write = 1'b0;
    endtask

    task automatic dc_op(input logic wr, input logic [31:0] a, input logic [LINE_W-1:0] d, output int lat);
        tick();
        dc_issue(wr, a, d);
        dc_finish(lat);
    endtask

    task automatic pf_pulse(input logic [31:0] a);
        tick();
        pf_addr  = a;
        pf_valid = 1'b1;
        tick();
        pf_valid = 1'b0;
    endtask

    task automatic prefetch_wait(input logic [31:0] a);
        int d0 = ops_done;
        int c = 0;
        pf_pulse(a);
        while (ops_done == d0 && c < 60) begin @(negedge clk); c++; end
        check("pf_completed", ops_done - d0, 1);
        check("pf_addr_issued", last_addr, line_of(a));
    endtask

    task automatic reset_zero_checks(input string tag);
        check({tag, "_mem_read"}, mem_read, 0);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_ic_resp"}, ic_resp, 0);
        check({tag, "_dc_resp"}, dc_resp, 0);
        check({tag, "_ic_rdata"}, ic_rdata, 0);
        check({tag, "_dc_rdata"}, dc_rdata, 0);
    endtask

    bit ic_done = 0;
    bit dc_done = 0;

    initial begin
        int lat, n0, c;
        logic [LINE_W-1:0] d;
        rst = 1'b1;
        ic_addr = '0; ic_read = 1'b0;
        dc_addr = '0; dc_read = 1'b0; dc_write = 1'b0; dc_wdata = '0;
        pf_addr = '0; pf_valid = 1'b0;
        repeat (3) tick();
        reset_zero_checks("reset");
        rst = 1'b0;
        tick();

        // 1: lone dcache read, memory answers 3 cycles after mem_read
        fixed_lat = 3;
        n0 = ops_started;
        dc_op(1'b0, 32'h100, '0, lat);
        check("t1_latency", lat, 4);
        check("t1_ops", ops_started - n0, 1);
        check("t1_addr", last_addr, 32'h100);
        check("t1_is_read", last_wr, 0);

        // 2: simultaneous demand, round-robin between pairs
        fixed_lat = 0;
        for (int p = 0; p < 2; p++) begin
            resp_log.delete();
            fork
                begin int l; ic_op(32'h040 + 32'(p) * 32'h40, l); end
                begin int l; dc_op(1'b0, 32'h1020 + 32'(p) * 32'h20, '0, l); end
            join
            check("t2_resp_count", resp_log.size(), 2);
            if (resp_log.size() == 2) begin
                check("t2_first", resp_log[0], (p == 0) ? 2 : 1);
                check("t2_second", resp_log[1], (p == 0) ? 1 : 2);
            end
        end

        // 3: prefetch fills buffer; icache hit responds same cycle without memory
        prefetch_wait(32'h220);
        n0 = ops_started;
        ic_op(32'h234, lat);
        check("t3_hit_latency", lat, 0);
        check("t3_hit_no_mem", ops_started - n0, 0);
        n0 = ops_started;
        ic_op(32'h234, lat);
        check("t3_buffer_consumed", ops_started - n0, 1);

        // 4: writeback to the buffered line invalidates it
        prefetch_wait(32'h220);
        d = rand_line();
        dc_op(1'b1, 32'h23C, d, lat);
        check("t4_write_addr", last_addr, 32'h220);
        check("t4_is_write", last_wr, 1);
        n0 = ops_started;
        ic_op(32'h220, lat);
        check("t4_refetch", ops_started - n0, 1);

        // 5: icache miss to the line being prefetched waits and then hits
        fixed_lat = 4;
        n0 = ops_started;
        pf_pulse(32'h240);
        c = 0;
        @(negedge clk);
        while (!mem_read && c < 20) begin c++; @(negedge clk); end
        check("t5_pf_started", mem_read, 1);
        ic_op(32'h240, lat);
        check("t5_single_fetch", ops_started - n0, 1);
        check("t5_resp_cycle", last_ic_cyc, last_resp_cyc + 1);

        // 6: asynchronous reset during a dcache read
        fixed_lat = 8;
        tick();
        dc_addr = 32'h1060;
        dc_read = 1'b1;
        c = 0;
        @(negedge clk);
        while (!mem_read && c < 20) begin c++; @(negedge clk); end
        check("t6_dc_granted", mem_addr, 32'h1060);
        tick();
        ic_issue(32'h080);
        tick();
        #1 rst = 1'b1;
        #1 reset_zero_checks("t6_async");
        dc_read = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        fixed_lat = 0;
        ic_finish(lat);
        check("t6_ic_addr", last_addr, 32'h080);

        // Random concurrent traffic with prefetch hints
        fork
            begin
                int l;
                for (int i = 0; i < 50; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    ic_op(32'($urandom_range(0, 15)) * 32 + 32'($urandom_range(0, 31)), l);
                end
                ic_done = 1;
            end
            begin
                int l;
                for (int i = 0; i < 50; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    dc_op(1'($urandom_range(0, 1)),
                          32'h1000 + 32'($urandom_range(0, 7)) * 32 + 32'($urandom_range(0, 31)),
                          rand_line(), l);
                end
                dc_done = 1;
            end
            begin
                while (!(ic_done && dc_done)) begin
                    repeat ($urandom_range(1, 6)) tick();
                    pf_pulse(32'($urandom_range(0, 15)) * 32 + 32'($urandom_range(0, 31)));
                end
            end
        join

        repeat (10) tick();
        check("ic_q_drained", ic_q.size(), 0);
        check("dc_q_drained", dc_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
